// File: rtl/reg_wb_arb.sv
// Writeback arbiter: merges single-cycle ALU results with a 2-entry load-response FIFO onto one register-file write port.
// Optional busy-register scoreboard with hazard query, enabled by defining WB_SCOREBOARD_EN.
module reg_wb_arb (
    input  logic        Wr_Clk,
    input  logic        Rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    input  logic [4:0]  q_rd,
    output logic        hazard,
    output logic        RegWr,
    output logic [4:0]  Rw,
    output logic [31:0] busW
);

    logic [4:0]  fifo_rd   [2];
    logic [31:0] fifo_data [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        take_alu;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    logic        sel_valid;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign ld_ready  = !full;
    assign alu_stall = alu_valid && full;
    assign push      = ld_valid && !full;

    // A full FIFO outranks the ALU so loads cannot starve indefinitely.
    assign pop       = full || (!alu_valid && !empty);
    assign take_alu  = alu_valid && !full;
    assign head_rd   = fifo_rd[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    always_comb begin
        sel_valid = pop || take_alu;
        sel_rd    = alu_rd;
        sel_data  = alu_data;
        if (pop) begin
            sel_rd   = head_rd;
            sel_data = head_data;
        end
    end

    always_ff @(posedge Wr_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_rd[i]   <= 5'd0;
                fifo_data[i] <= 32'd0;
            end
        end else begin
            if (push) begin
                fifo_rd[wr_ptr]   <= ld_rd;
                fifo_data[wr_ptr] <= ld_data;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Writes to x0 are consumed silently; Rw/busW keep their last real write.
    always_ff @(posedge Wr_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RegWr <= 1'b0;
            Rw    <= 5'd0;
            busW  <= 32'd0;
        end else begin
            RegWr <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid && (sel_rd != 5'd0)) begin
                Rw   <= sel_rd;
                busW <= sel_data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (ld_issue) begin
            set_mask[ld_issue_rd] = 1'b1;
        end
        if (pop) begin
            clr_mask[head_rd] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle issue to the retiring register wins.
    always_ff @(posedge Wr_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy <= 32'd0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
        end
    end

    assign hazard = busy[q_rs1] | busy[q_rs2] | busy[q_rd];
`else
    logic unused_sb;
    assign unused_sb = ^{ld_issue, ld_issue_rd, q_rs1, q_rs2, q_rd};
    assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arb.sv
// Directed self-checking bench for reg_wb_arb; works with or without WB_SCOREBOARD_EN.
module tb_reg_wb_arb;

    logic        Wr_Clk;
    logic        Rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic [4:0]  q_rd;
    logic        hazard;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;

    int vectors;
    int miscompares;
    logic [31:0] busy_model;

`ifdef WB_SCOREBOARD_EN
    localparam bit SbEn = 1'b1;
`else
    localparam bit SbEn = 1'b0;
`endif

    reg_wb_arb dut (
        .Wr_Clk      (Wr_Clk),
        .Rst_n       (Rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_stall   (alu_stall),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .q_rs1       (q_rs1),
        .q_rs2       (q_rs2),
        .q_rd        (q_rd),
        .hazard      (hazard),
        .RegWr       (RegWr),
        .Rw          (Rw),
        .busW        (busW)
    );

    initial Wr_Clk = 1'b0;
    always #5 Wr_Clk = ~Wr_Clk;

    task automatic tick();
        @(posedge Wr_Clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (RegWr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_regwr got %0b want 0", RegWr); end
        vectors++;
        if (Rw !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_rw got %0d want 0", Rw); end
        vectors++;
        if (busW !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_busw got %h want 0", busW); end
        vectors++;
        if (ld_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ld_ready got %0b want 1", ld_ready); end
        vectors++;
        if (alu_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_alu_stall got %0b want 0", alu_stall); end
        vectors++;
        if (hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_hazard got %0b want 0", hazard); end
        tick();
        Rst_n = 1'b1;
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
        tick();
        alu_valid = 1'b0;
        vectors++;
        if (RegWr !== 1'b1 || Rw !== 5'd5 || busW !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL alu_write got %0b/%0d/%h want 1/5/12345678", RegWr, Rw, busW);
        end
        tick();
        vectors++;
        if (RegWr !== 1'b0 || Rw !== 5'd5 || busW !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL alu_idle_hold got %0b/%0d/%h want 0/5/12345678", RegWr, Rw, busW);
        end
    endtask

    task automatic test_load_behind_alu();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hA5A5_A5A5;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'h100 + 32'(i);
            tick();
            ld_valid = 1'b0;
            vectors++;
            if (RegWr !== 1'b1 || Rw !== 5'(10 + i) || busW !== 32'h100 + 32'(i)) begin
                miscompares++;
                $display("[TB] FAIL alu_over_load[%0d] got %0b/%0d/%h want 1/%0d/%h",
                         i, RegWr, Rw, busW, 10 + i, 32'h100 + 32'(i));
            end
        end
        alu_valid = 1'b0;
        tick();
        vectors++;
        if (RegWr !== 1'b1 || Rw !== 5'd7 || busW !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("[TB] FAIL load_after_alu got %0b/%0d/%h want 1/7/a5a5a5a5", RegWr, Rw, busW);
        end
        tick();
        vectors++;
        if (RegWr !== 1'b0) begin miscompares++; $display("[TB] FAIL load_drained got %0b want 0", RegWr); end
    endtask

    task automatic test_fifo_full();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h200;
        ld_valid  = 1'b1; ld_rd  = 5'd3;  ld_data  = 32'h33;
        tick();
        vectors++;
        if (Rw !== 5'd20 || ld_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_step1 got rw=%0d rdy=%0b want 20/1", Rw, ld_ready);
        end
        alu_rd = 5'd21; alu_data = 32'h201;
        ld_rd  = 5'd4;  ld_data  = 32'h44;
        tick();
        ld_valid = 1'b0;
        alu_rd = 5'd22; alu_data = 32'h202;
        #1;
        vectors++;
        if (Rw !== 5'd21 || ld_ready !== 1'b0 || alu_stall !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_stall got rw=%0d rdy=%0b stall=%0b want 21/0/1", Rw, ld_ready, alu_stall);
        end
        tick();
        vectors++;
        if (RegWr !== 1'b1 || Rw !== 5'd3 || busW !== 32'h33 || alu_stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_pop3 got %0b/%0d/%h stall=%0b want 1/3/33 stall=0", RegWr, Rw, busW, alu_stall);
        end
        tick();
        alu_valid = 1'b0;
        vectors++;
        if (RegWr !== 1'b1 || Rw !== 5'd22 || busW !== 32'h202) begin
            miscompares++;
            $display("[TB] FAIL held_alu got %0b/%0d/%h want 1/22/202", RegWr, Rw, busW);
        end
        tick();
        vectors++;
        if (RegWr !== 1'b1 || Rw !== 5'd4 || busW !== 32'h44) begin
            miscompares++;
            $display("[TB] FAIL full_pop4 got %0b/%0d/%h want 1/4/44", RegWr, Rw, busW);
        end
        tick();
        vectors++;
        if (RegWr !== 1'b0) begin miscompares++; $display("[TB] FAIL full_drained got %0b want 0", RegWr); end
    endtask

    task automatic test_rd_zero();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        tick();
        alu_valid = 1'b0;
        vectors++;
        if (RegWr !== 1'b0) begin miscompares++; $display("[TB] FAIL alu_x0 got %0b want 0", RegWr); end
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hDEAD;
        tick();
        ld_valid = 1'b0;
        tick();
        vectors++;
        if (RegWr !== 1'b0) begin miscompares++; $display("[TB] FAIL load_x0 got %0b want 0", RegWr); end
        // An empty FIFO takes two ALU-shadowed loads before reporting full.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 32'h66;
        tick();
        vectors++;
        if (Rw !== 5'd1 || ld_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL x0_empty got rw=%0d rdy=%0b want 1/1", Rw, ld_ready);
        end
        alu_rd = 5'd2; alu_data = 32'h2;
        ld_rd  = 5'd8; ld_data  = 32'h88;
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        vectors++;
        if (Rw !== 5'd2 || ld_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_full got rw=%0d rdy=%0b want 2/0", Rw, ld_ready);
        end
        tick();
        vectors++;
        if (RegWr !== 1'b1 || Rw !== 5'd6 || busW !== 32'h66) begin
            miscompares++;
            $display("[TB] FAIL wrap_pop6 got %0b/%0d/%h want 1/6/66", RegWr, Rw, busW);
        end
        tick();
        vectors++;
        if (RegWr !== 1'b1 || Rw !== 5'd8 || busW !== 32'h88) begin
            miscompares++;
            $display("[TB] FAIL wrap_pop8 got %0b/%0d/%h want 1/8/88", RegWr, Rw, busW);
        end
        tick();
    endtask

    task automatic test_hazard();
        vectors++;
        if (busy_model[9] === 1'b1) begin miscompares++; $display("[TB] FAIL illegal_issue rd=9 already busy got 1 want 0"); end
        ld_issue = 1'b1; ld_issue_rd = 5'd9; q_rs1 = 5'd9;
        #1;
        vectors++;
        if (hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL hazard_pre got %0b want 0", hazard); end
        tick();
        busy_model[9] = SbEn;
        ld_issue = 1'b0;
        vectors++;
        if (hazard !== busy_model[9]) begin miscompares++; $display("[TB] FAIL hazard_set got %0b want %0b", hazard, busy_model[9]); end
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        tick();
        ld_valid = 1'b0;
        vectors++;
        if (hazard !== busy_model[9] || RegWr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hazard_hold got %0b/%0b want %0b/0", hazard, RegWr, busy_model[9]);
        end
        tick();
        busy_model[9] = 1'b0;
        vectors++;
        if (hazard !== 1'b0 || RegWr !== 1'b1 || Rw !== 5'd9 || busW !== 32'h99) begin
            miscompares++;
            $display("[TB] FAIL hazard_clear got %0b/%0b/%0d/%h want 0/1/9/99", hazard, RegWr, Rw, busW);
        end
        q_rs1 = 5'd0;
        tick();
    endtask

    task automatic test_reset_midop();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        ld_valid  = 1'b1; ld_rd  = 5'd12; ld_data = 32'hCC;
        ld_issue  = 1'b1; ld_issue_rd = 5'd13; q_rs1 = 5'd13;
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0; ld_issue = 1'b0;
        Rst_n = 1'b0;
        #1;
        vectors++;
        if (RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL midreset_regs got %0b/%0d/%h want 0/0/0", RegWr, Rw, busW);
        end
        vectors++;
        if (ld_ready !== 1'b1 || alu_stall !== 1'b0 || hazard !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_flags got rdy=%0b stall=%0b hz=%0b want 1/0/0", ld_ready, alu_stall, hazard);
        end
        tick();
        Rst_n = 1'b1;
        q_rs1 = 5'd0;
        tick();
        vectors++;
        if (RegWr !== 1'b0) begin miscompares++; $display("[TB] FAIL flushed_write got %0b want 0", RegWr); end
        tick();
        vectors++;
        if (RegWr !== 1'b0 || Rw !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL flushed_idle got %0b/%0d want 0/0", RegWr, Rw);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; busy_model = 32'd0;
        Rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
        ld_issue = 1'b0; ld_issue_rd = 5'd0;
        q_rs1 = 5'd0; q_rs2 = 5'd0; q_rd = 5'd0;
        test_reset();
        test_alu_single();
        test_load_behind_alu();
        test_fifo_full();
        test_rd_zero();
        test_hazard();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
